// File: rtl/hwag_tooth_sync_if.sv
// Crank sync bundle: capture inputs (edge/period/overflow/enable) and sync status outputs.
// Master drives the capture side, slave is the sync controller.
interface hwag_tooth_sync_if #(
    parameter int PCNT_W = 24,
    parameter int TCNT_W = 8
);
    logic              ena;
    logic              edge_vld;
    logic [PCNT_W-1:0] period;
    logic              pcnt_ovf;
    logic              sync;
    logic [1:0]        state;
    logic [TCNT_W-1:0] tooth_num;
    logic [PCNT_W-1:0] last_period;
    logic              gap_flag;
    logic              sync_err;

    modport master (
        output ena, edge_vld, period, pcnt_ovf,
        input  sync, state, tooth_num, last_period, gap_flag, sync_err
    );

    modport slave (
        input  ena, edge_vld, period, pcnt_ovf,
        output sync, state, tooth_num, last_period, gap_flag, sync_err
    );
endinterface

// File: rtl/hwag_tooth_sync.sv
// Crank-wheel sync: detects the missing-tooth gap, counts teeth, flags sync loss.
// Latency: 1 cycle, all outputs registered on the edge that samples edge_vld/pcnt_ovf.
// Backpressure: none; every capture strobe is consumed in the cycle it arrives.
module hwag_tooth_sync #(
    parameter int PCNT_W = 24,
    parameter int TCNT_W = 8,
    parameter int TEETH  = 58
) (
    input  logic               clk,
    input  logic               rst,
    hwag_tooth_sync_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, SEARCH = 2'd2, SYNC = 2'd3} state_t;

    localparam logic [TCNT_W-1:0] LAST_TOOTH = TCNT_W'(TEETH - 1);

    state_t            state_q, state_d;
    logic              arm_q, arm_d;
    logic [TCNT_W-1:0] tooth_q, tooth_d;
    logic [PCNT_W-1:0] lp_q, lp_d;
    logic              gap_q, gap_d;
    logic              err_q, err_d;
    logic              sync_q;
    logic              gap;

    // One extra bit on both sides so 2*last_period cannot wrap.
    assign gap = ({1'b0, bus.period} >= {lp_q, 1'b0});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            arm_q   <= 1'b0;
            tooth_q <= '0;
            lp_q    <= '0;
            gap_q   <= 1'b0;
            err_q   <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            tooth_q <= tooth_d;
            lp_q    <= lp_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            sync_q  <= (state_d == SYNC);
        end
    end

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        tooth_d = tooth_q;
        lp_d    = lp_q;
        gap_d   = 1'b0;
        err_d   = 1'b0;
        if (!bus.ena) begin
            state_d = IDLE;
            arm_d   = 1'b0;
            tooth_d = '0;
            lp_d    = '0;
        end else if (bus.pcnt_ovf && state_q != IDLE) begin
            // Engine stalled: restart acquisition from scratch.
            err_d   = (state_q == SYNC);
            state_d = ARM;
            arm_d   = 1'b0;
            tooth_d = '0;
            lp_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    arm_d   = 1'b0;
                end
                ARM: if (bus.edge_vld) begin
                    // First period after start is partial and is dropped.
                    if (!arm_q) begin
                        arm_d = 1'b1;
                    end else begin
                        lp_d    = bus.period;
                        state_d = SEARCH;
                    end
                end
                SEARCH: if (bus.edge_vld) begin
                    if (gap) begin
                        state_d = SYNC;
                        tooth_d = '0;
                        gap_d   = 1'b1;
                    end else begin
                        lp_d = bus.period;
                    end
                end
                SYNC: if (bus.edge_vld) begin
                    if (tooth_q != LAST_TOOTH) begin
                        if (gap) begin
                            err_d   = 1'b1;
                            state_d = SEARCH;
                            tooth_d = '0;
                        end else begin
                            tooth_d = tooth_q + 1'b1;
                            lp_d    = bus.period;
                        end
                    end else if (gap) begin
                        tooth_d = '0;
                        gap_d   = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                        tooth_d = '0;
                        lp_d    = bus.period;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.sync        = sync_q;
    assign bus.state       = state_q;
    assign bus.tooth_num   = tooth_q;
    assign bus.last_period = lp_q;
    assign bus.gap_flag    = gap_q;
    assign bus.sync_err    = err_q;
endmodule

// File: tb/tb_hwag_tooth_sync.sv
// Bench for hwag_tooth_sync: directed scenarios plus a randomized wheel, each
// compared against a revolution-level reference model.
module tb_hwag_tooth_sync;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    hwag_tooth_sync_if #(.PCNT_W(24), .TCNT_W(8)) bus ();

    hwag_tooth_sync #(.PCNT_W(24), .TCNT_W(8), .TEETH(58)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0=off 1=arming 2=hunting 3=locked.
    int     m_phase;
    int     m_edges_armed;
    int     m_tooth;
    longint m_ref;
    bit     m_gap, m_err;

    function automatic logic [36:0] expv();
        return {m_phase == 3, 2'(m_phase), 8'(m_tooth), 24'(m_ref), m_gap, m_err};
    endfunction

    function automatic logic [36:0] actv();
        return {bus.sync, bus.state, bus.tooth_num, bus.last_period, bus.gap_flag, bus.sync_err};
    endfunction

    function automatic void model_clear();
        m_phase = 0; m_edges_armed = 0; m_tooth = 0; m_ref = 0; m_gap = 0; m_err = 0;
    endfunction

    function automatic void model_step(bit en, bit e, longint p, bit ovf);
        bit is_gap;
        m_gap = 0; m_err = 0;
        if (!en) begin
            model_clear();
            return;
        end
        if (ovf && m_phase != 0) begin
            m_err = (m_phase == 3);
            m_phase = 1; m_edges_armed = 0; m_tooth = 0; m_ref = 0;
            return;
        end
        if (m_phase == 0) begin
            m_phase = 1; m_edges_armed = 0;
            return;
        end
        if (!e) return;
        is_gap = (p >= 2 * m_ref);
        if (m_phase == 1) begin
            m_edges_armed++;
            if (m_edges_armed == 2) begin
                m_ref = p; m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (is_gap) begin
                m_phase = 3; m_tooth = 0; m_gap = 1;
            end else m_ref = p;
        end else begin
            if (is_gap && m_tooth == 57) begin
                m_tooth = 0; m_gap = 1;
            end else if (!is_gap && m_tooth < 57) begin
                m_tooth++; m_ref = p;
            end else begin
                m_err = 1; m_phase = 2; m_tooth = 0;
                if (!is_gap) m_ref = p;
            end
        end
    endfunction

    task automatic cycle(input bit en, input bit e, input logic [23:0] p, input bit ovf);
        bus.ena = en; bus.edge_vld = e; bus.period = p; bus.pcnt_ovf = ovf;
        @(posedge clk);
        model_step(en, e, longint'(p), ovf);
        #1;
        bus.edge_vld = 1'b0; bus.pcnt_ovf = 1'b0;
    endtask

    task automatic bring_to_sync();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 24'd37, 0);
        cycle(1, 1, 24'd100, 0);
        cycle(1, 1, 24'd100, 0);
        cycle(1, 1, 24'd300, 0);
    endtask

    task automatic test_reset();
        model_clear();
        bus.ena = 0; bus.edge_vld = 0; bus.period = 0; bus.pcnt_ovf = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (actv() !== 37'd0) begin
            errors++; $display("FAIL reset_init: got %h want 0", actv());
        end
        rst = 1'b1;
        bring_to_sync();
        repeat (20) cycle(1, 1, 24'd100, 0);
        checks++;
        if (bus.tooth_num !== 8'd20 || bus.state !== 2'd3) begin
            errors++; $display("FAIL reset_pre: tooth %0d state %0d want 20/3", bus.tooth_num, bus.state);
        end
        #2 rst = 1'b0;
        #1;
        model_clear();
        checks++;
        if (actv() !== 37'd0) begin
            errors++; $display("FAIL reset_async: got %h want 0", actv());
        end
        #2 rst = 1'b1;
        cycle(1, 0, 0, 0);
        checks++;
        if (bus.state !== 2'd1) begin
            errors++; $display("FAIL reset_release: state %0d want 1", bus.state);
        end
    endtask

    task automatic test_acquire();
        int gaps = 0;
        logic [23:0] seq [5] = '{24'd37, 24'd100, 24'd100, 24'd100, 24'd300};
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        foreach (seq[i]) begin
            cycle(1, 1, seq[i], 0);
            gaps += bus.gap_flag;
            checks++;
            if (actv() !== expv()) begin
                errors++; $display("FAIL acquire_step%0d: got %h want %h", i, actv(), expv());
            end
        end
        checks++;
        if (bus.state !== 2'd3 || bus.tooth_num !== 8'd0 || bus.last_period !== 24'd100 || gaps != 1) begin
            errors++; $display("FAIL acquire_end: state %0d tooth %0d lp %0d gaps %0d want 3/0/100/1",
                               bus.state, bus.tooth_num, bus.last_period, gaps);
        end
    endtask

    task automatic test_full_rev();
        int bad = 0;
        for (int t = 1; t <= 57; t++) begin
            cycle(1, 1, 24'd100, 0);
            if (bus.tooth_num !== 8'(t) || bus.sync_err !== 1'b0 || bus.sync !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rev_count: %0d bad teeth want 0", bad);
        end
        cycle(1, 1, 24'd300, 0);
        checks++;
        if (bus.tooth_num !== 8'd0 || bus.gap_flag !== 1'b1 || bus.sync !== 1'b1 || bus.sync_err !== 1'b0) begin
            errors++; $display("FAIL rev_wrap: got %h want tooth 0 gap 1 sync 1", actv());
        end
    endtask

    task automatic test_errors();
        repeat (30) cycle(1, 1, 24'd100, 0);
        cycle(1, 1, 24'd300, 0);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.state !== 2'd2 || bus.tooth_num !== 8'd0 || bus.last_period !== 24'd100) begin
            errors++; $display("FAIL early_gap: got %h want err 1 state 2 lp 100", actv());
        end
        cycle(1, 1, 24'd300, 0);
        repeat (57) cycle(1, 1, 24'd100, 0);
        checks++;
        if (bus.tooth_num !== 8'd57) begin
            errors++; $display("FAIL missing_pre: tooth %0d want 57", bus.tooth_num);
        end
        cycle(1, 1, 24'd100, 0);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.state !== 2'd2 || bus.tooth_num !== 8'd0) begin
            errors++; $display("FAIL missing_gap: got %h want err 1 state 2", actv());
        end
    endtask

    task automatic test_boundary();
        cycle(1, 1, 24'd100, 0);
        cycle(1, 1, 24'd199, 0);
        checks++;
        if (bus.state !== 2'd2 || bus.gap_flag !== 1'b0 || bus.last_period !== 24'd199) begin
            errors++; $display("FAIL gap_199: got %h want state 2 no gap lp 199", actv());
        end
        cycle(1, 1, 24'd100, 0);
        cycle(1, 1, 24'd200, 0);
        checks++;
        if (bus.state !== 2'd3 || bus.gap_flag !== 1'b1) begin
            errors++; $display("FAIL gap_200: got %h want state 3 gap 1", actv());
        end
        cycle(1, 0, 0, 1);
        cycle(1, 1, 24'hFFFFFF, 0);
        cycle(1, 1, 24'hFFFFFF, 0);
        cycle(1, 1, 24'hFFFFFF, 0);
        checks++;
        if (bus.state !== 2'd2 || bus.gap_flag !== 1'b0 || bus.last_period !== 24'hFFFFFF) begin
            errors++; $display("FAIL gap_max: got %h want state 2 no gap lp ffffff", actv());
        end
    endtask

    task automatic test_stall_disable();
        cycle(1, 1, 24'd100, 0);
        cycle(1, 1, 24'd300, 0);
        cycle(1, 1, 24'd100, 1);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.state !== 2'd1 || bus.tooth_num !== 8'd0 || bus.last_period !== 24'd0) begin
            errors++; $display("FAIL ovf_sync: got %h want err 1 state 1 tooth 0 lp 0", actv());
        end
        bring_to_sync();
        cycle(1, 1, 24'd100, 0);
        cycle(0, 1, 24'd100, 0);
        checks++;
        if (bus.state !== 2'd0 || bus.sync_err !== 1'b0 || bus.tooth_num !== 8'd0 || bus.last_period !== 24'd0) begin
            errors++; $display("FAIL disable: got %h want all 0", actv());
        end
    endtask

    task automatic test_random();
        int pos = 0;
        int bad = 0;
        bit en, e, ovf;
        logic [23:0] p;
        for (int c = 0; c < 4000; c++) begin
            en  = ($urandom_range(0, 499) != 0);
            ovf = ($urandom_range(0, 799) == 0);
            e   = ($urandom_range(0, 2) != 0);
            p   = 24'd0;
            if (e) begin
                if ($urandom_range(0, 99) == 0)
                    p = 24'($urandom_range(1, 400));
                else if (pos == 0)
                    p = 24'($urandom_range(250, 350));
                else
                    p = 24'($urandom_range(90, 110));
                pos = (pos + 1) % 58;
            end
            cycle(en, e, p, ovf);
            checks++;
            if (actv() !== expv()) begin
                errors++; bad++;
                if (bad <= 5) $display("FAIL random_c%0d: got %h want %h", c, actv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_full_rev();
        test_errors();
        test_boundary();
        test_stall_disable();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
